// File: rtl/key_led_pkg.sv
// Shared types for the key-driven LED controller: LED mode encoding and
// debounce FSM states.
package key_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        DB_IDLE         = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_HELD         = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } deb_state_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus debounce FSM. press_accept is the D input of the
// press_pulse flop so the parent can update its own state on the same edge.
module key_debounce
    import key_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic press_accept,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_reg;
    logic          key_s;
    deb_state_t    state_reg;
    logic [CW-1:0] cnt_reg;
    logic          cnt_done;

    assign key_s    = sync_reg[1];
    // The sample being taken now is the one that completes the stable run.
    assign cnt_done = (int'(cnt_reg) + 1) >= DEBOUNCE_CYCLES;

    assign press_accept = key_s &&
        (((state_reg == DB_IDLE) && (DEBOUNCE_CYCLES == 1)) ||
         ((state_reg == DB_PRESS_WAIT) && cnt_done));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg    <= 2'b00;
            state_reg   <= DB_IDLE;
            cnt_reg     <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], key_raw};
            press_pulse <= press_accept;
            case (state_reg)
                DB_IDLE: begin
                    if (key_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_reg <= DB_HELD;
                            cnt_reg   <= '0;
                        end else begin
                            state_reg <= DB_PRESS_WAIT;
                            cnt_reg   <= CW'(1);
                        end
                    end
                end
                DB_PRESS_WAIT: begin
                    if (!key_s) begin
                        state_reg <= DB_IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_done) begin
                        state_reg <= DB_HELD;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DB_HELD: begin
                    if (!key_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_reg <= DB_IDLE;
                            cnt_reg   <= '0;
                        end else begin
                            state_reg <= DB_RELEASE_WAIT;
                            cnt_reg   <= CW'(1);
                        end
                    end
                end
                DB_RELEASE_WAIT: begin
                    // A bounce back high returns to HELD silently: no second pulse.
                    if (key_s) begin
                        state_reg <= DB_HELD;
                        cnt_reg   <= '0;
                    end else if (cnt_done) begin
                        state_reg <= DB_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= DB_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_led_ctrl.sv
// Cycles the LED through OFF/ON/SLOW/FAST on each debounced key press and
// drives the blink pattern for the current mode.
module key_led_ctrl
    import key_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BLINK_SLOW      = 8,
    parameter int BLINK_FAST      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key1,
    output logic       led0,
    output logic [1:0] mode,
    output logic       press_pulse
);

    localparam int BMAX = (BLINK_SLOW > BLINK_FAST) ? BLINK_SLOW : BLINK_FAST;
    localparam int BW   = $clog2(BMAX + 1);

    logic          press_accept;
    mode_t         mode_reg;
    mode_t         mode_next;
    logic [BW-1:0] blink_reg;
    logic          led_reg;
    logic          blink_wrap;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .key_raw     (key1),
        .press_accept(press_accept),
        .press_pulse (press_pulse)
    );

    assign mode_next = mode_t'(mode_reg + 2'd1);
    assign mode      = mode_reg;
    assign led0      = led_reg;

    always_comb begin
        blink_wrap = 1'b0;
        if (mode_reg == MODE_SLOW) begin
            blink_wrap = (blink_reg == BW'(BLINK_SLOW - 1));
        end else if (mode_reg == MODE_FAST) begin
            blink_wrap = (blink_reg == BW'(BLINK_FAST - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_reg  <= MODE_OFF;
            blink_reg <= '0;
            led_reg   <= 1'b0;
        end else if (press_accept) begin
            // Mode entry: restart the blink phase with the LED lit (except OFF).
            mode_reg  <= mode_next;
            blink_reg <= '0;
            led_reg   <= (mode_next != MODE_OFF);
        end else if ((mode_reg == MODE_SLOW) || (mode_reg == MODE_FAST)) begin
            if (blink_wrap) begin
                blink_reg <= '0;
                led_reg   <= ~led_reg;
            end else begin
                blink_reg <= blink_reg + 1'b1;
            end
        end else begin
            blink_reg <= '0;
            led_reg   <= (mode_reg == MODE_ON);
        end
    end

endmodule
